reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Write-port arbiter and scheduler for the 32x32 register file. It shares the register file's single write port between two writeback requesters, the ALU result path (source 0) and the load/memory result path (source 1). Each source gets a small input queue behind a valid/ready handshake. Queued entries are granted one per cycle onto a registered write port that drives the register file write inputs, and a pending-write hit signal is exported for each read address so decode can stall on hazards.

## Interface
Parameters:
- QDEPTH, 2, entries per source queue; power of two, ≥2
- DW, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- WBA_s0_valid  in  1  ALU writeback request
- WBA_s0_addr  in  AW  ALU destination register
- WBA_s0_data  in  DW  ALU result
- WBA_s0_ready  out  1  source-0 queue can accept
- WBA_s1_valid / WBA_s1_addr / WBA_s1_data  in  1/AW/DW  load writeback request
- WBA_s1_ready  out  1  source-1 queue can accept
- REG_write_1  out  1  register file write enable (registered)
- REG_address_wr  out  AW  register file write address (registered)
- REG_data_wb_in1  out  DW  register file write data (registered)
- REG_address1 / REG_address2  in  AW  decode read addresses, monitored only
- WBA_pend_hit1 / WBA_pend_hit2  out  1  read address has a write not yet committed
- WBA_busy  out  1  any queue non-empty or REG_write_1 high

## Operation
- Accept: a transfer occurs when valid && ready at a rising edge. The entry {addr, data} is pushed to that source's FIFO queue.
- ready = (count < QDEPTH), taken from registered count only. A full queue deasserts ready even in a cycle in which it pops; there is no combinational valid→ready path.
- Arbitration: each cycle, if any queue is non-empty, exactly one head entry is popped.
  - Fixed priority by default: source 1 wins over source 0.
- Grant with addr ≠ 0: on the pop edge the output registers load REG_write_1=1, REG_address_wr=addr, REG_data_wb_in1=data.
- Grant with addr = 0: the entry is popped and discarded, REG_write_1=0. Register 0 is never written.
- No grant: REG_write_1=0. Address and data hold their last values.
- Hazard: WBA_pend_hit1 is high when REG_address1 ≠ 0 and it matches any valid entry in either queue, or matches REG_address_wr while REG_write_1=1. WBA_pend_hit2 is the same check for REG_address2.
  - Both hit outputs are combinational from registered state plus the read address.
- Ordering: FIFO order is preserved within a source. Across sources, order is grant order only. Upstream must use the pend_hit outputs to avoid write-after-write reordering on the same address.
- Count arithmetic: count is log2(QDEPTH)+1 bits wide. Read and write pointers are log2(QDEPTH) bits and wrap modulo QDEPTH. Push and pop on the same edge leave count unchanged.

## Timing
- Reset values: all queues empty, count=0, pointers=0, REG_write_1=0, REG_address_wr=0, REG_data_wb_in1=0, WBA_s0_ready=1, WBA_s1_ready=1, WBA_busy=0, pend_hit outputs=0 (apart from their combinational dependence on address inputs against empty state).
- Latency, counting from accept edge E0:
  - earliest grant and output load at E1;
  - register file captures at E2.
- Throughput: one write per cycle total. A lone source with continuous valid sustains full rate with QDEPTH=2.
- Reset asserted mid-operation: all queued and registered writes are dropped immediately (asynchronous), and REG_write_1 falls without waiting for a clock edge.
- Simultaneous pushes on both sources are both accepted when both have space.

## Configuration
- WB_ARB_RR_EN defined: round-robin replaces fixed priority.
  - A last-grant flag, reset to 1, selects the other source when both queues are non-empty, so source 0 wins the first contention after reset.
  - The flag updates only on a contested grant.
- WB_ARB_RR_EN undefined: fixed priority, source 1 first. The last-grant flag is not built.

## Test plan
- Reset, then s0 pushes (addr 3, 0xDEADBEEF) at E0 → REG_write_1=1, addr 3, data 0xDEADBEEF after E1. Register 3 reads 0xDEADBEEF after E2. busy low after E2.
- s0 (5, 0x11) and s1 (6, 0x22) pushed on the same edge, fixed priority → writes to 6 then 5 on consecutive cycles. With WB_ARB_RR_EN → 5 then 6.
- s1 holds valid for 6 cycles while s0 also streams → s0 ready drops after its 2nd queued entry. Without RR, s0 is granted only once s1 drains. With RR, grants alternate.
- Push addr 0 with data 0xFFFFFFFF → entry popped, REG_write_1 stays 0, register 0 remains 0, pend_hit never asserts for address 0.
- Queue (7, 0xAA) while REG_address1=7 → pend_hit1 high from the edge after acceptance through the edge at which the register file commits, then low. REG_address2=8 keeps pend_hit2 low.
- Two entries queued in each source, then rst_n pulled low mid-cycle → REG_write_1 and busy low immediately. After release both readies are 1 and no stale write appears.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: queues ALU (src 0) and load (src 1) results and grants one per cycle onto the register-file write port.
// Optional WB_ARB_RR_EN selects round-robin arbitration instead of fixed priority (source 1 first).
module reg_wb_arbiter #(
  parameter int QDEPTH = 2,
  parameter int DW     = 32,
  parameter int AW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          WBA_s0_valid,
  input  logic [AW-1:0] WBA_s0_addr,
  input  logic [DW-1:0] WBA_s0_data,
  output logic          WBA_s0_ready,
  input  logic          WBA_s1_valid,
  input  logic [AW-1:0] WBA_s1_addr,
  input  logic [DW-1:0] WBA_s1_data,
  output logic          WBA_s1_ready,
  output logic          REG_write_1,
  output logic [AW-1:0] REG_address_wr,
  output logic [DW-1:0] REG_data_wb_in1,
  input  logic [AW-1:0] REG_address1,
  input  logic [AW-1:0] REG_address2,
  output logic          WBA_pend_hit1,
  output logic          WBA_pend_hit2,
  output logic          WBA_busy
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [1:0]           src_valid;
  logic [1:0][AW-1:0]   src_addr;
  logic [1:0][DW-1:0]   src_data;
  logic [1:0]           src_ready;
  logic [1:0]           src_nonempty;
  logic [1:0]           src_pop;
  logic [1:0][AW-1:0]   head_addr;
  logic [1:0][DW-1:0]   head_data;
  logic [1:0]           q_hit1;
  logic [1:0]           q_hit2;

  logic                 grant_any;
  logic                 grant_src;
  logic [AW-1:0]        grant_addr;
  logic [DW-1:0]        grant_data;

  logic                 wr_en_reg;
  logic [AW-1:0]        wr_addr_reg;
  logic [DW-1:0]        wr_data_reg;

  assign src_valid = {WBA_s1_valid, WBA_s0_valid};
  assign src_addr  = {WBA_s1_addr, WBA_s0_addr};
  assign src_data  = {WBA_s1_data, WBA_s0_data};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_queue
      logic [AW-1:0] q_addr [QDEPTH];
      logic [DW-1:0] q_data [QDEPTH];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [CW-1:0] count_reg;
      logic [QDEPTH-1:0] ent_valid;
      logic [QDEPTH-1:0] ent_match1;
      logic [QDEPTH-1:0] ent_match2;
      logic push;

      // Ready is derived from the registered count only, so a full queue stays closed even while popping.
      assign src_ready[gi]    = (count_reg < CW'(QDEPTH));
      assign src_nonempty[gi] = (count_reg != '0);
      assign push             = src_valid[gi] && src_ready[gi];
      assign head_addr[gi]    = q_addr[rd_ptr_reg];
      assign head_data[gi]    = q_data[rd_ptr_reg];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (src_pop[gi])
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
          case ({push, src_pop[gi]})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (push) begin
          q_addr[wr_ptr_reg] <= src_addr[gi];
          q_data[wr_ptr_reg] <= src_data[gi];
        end
      end

      // An entry is live when its distance from the read pointer is below the count.
      genvar gj;
      for (gj = 0; gj < QDEPTH; gj++) begin : g_ent
        logic [PW-1:0] off;
        assign off            = PW'(gj) - rd_ptr_reg;
        assign ent_valid[gj]  = ({1'b0, off} < count_reg);
        assign ent_match1[gj] = (q_addr[gj] == REG_address1);
        assign ent_match2[gj] = (q_addr[gj] == REG_address2);
      end

      assign q_hit1[gi] = |(ent_valid & ent_match1);
      assign q_hit2[gi] = |(ent_valid & ent_match2);
    end
  endgenerate

`ifdef WB_ARB_RR_EN
  logic last_grant_reg;

  always_comb begin
    grant_any = |src_nonempty;
    if (&src_nonempty)
      grant_src = ~last_grant_reg;
    else
      grant_src = src_nonempty[1];
  end

  // Only contested grants move the flag, so an idle source does not lose its turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant_reg <= 1'b1;
    else if (&src_nonempty)
      last_grant_reg <= grant_src;
  end
`else
  always_comb begin
    grant_any = |src_nonempty;
    grant_src = src_nonempty[1];
  end
`endif

  assign src_pop[0] = grant_any && !grant_src;
  assign src_pop[1] = grant_any && grant_src;
  assign grant_addr = head_addr[grant_src];
  assign grant_data = head_data[grant_src];

  // Grants to register 0 are consumed without a write; address/data hold their previous values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else if (grant_any && (grant_addr != '0)) begin
      wr_en_reg   <= 1'b1;
      wr_addr_reg <= grant_addr;
      wr_data_reg <= grant_data;
    end else begin
      wr_en_reg   <= 1'b0;
    end
  end

  assign REG_write_1     = wr_en_reg;
  assign REG_address_wr  = wr_addr_reg;
  assign REG_data_wb_in1 = wr_data_reg;
  assign WBA_s0_ready    = src_ready[0];
  assign WBA_s1_ready    = src_ready[1];
  assign WBA_busy        = (|src_nonempty) || wr_en_reg;

  assign WBA_pend_hit1 = (REG_address1 != '0) &&
                         ((|q_hit1) || (wr_en_reg && (wr_addr_reg == REG_address1)));
  assign WBA_pend_hit2 = (REG_address2 != '0) &&
                         ((|q_hit2) || (wr_en_reg && (wr_addr_reg == REG_address2)));

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter in its default (fixed-priority) build.
module tb_reg_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          s0_valid, s1_valid;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_ready, s1_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic          hit1, hit2;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  reg_wb_arbiter #(.QDEPTH(2), .DW(DW), .AW(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .WBA_s0_valid    (s0_valid),
    .WBA_s0_addr     (s0_addr),
    .WBA_s0_data     (s0_data),
    .WBA_s0_ready    (s0_ready),
    .WBA_s1_valid    (s1_valid),
    .WBA_s1_addr     (s1_addr),
    .WBA_s1_data     (s1_data),
    .WBA_s1_ready    (s1_ready),
    .REG_write_1     (wr_en),
    .REG_address_wr  (wr_addr),
    .REG_data_wb_in1 (wr_data),
    .REG_address1    (rd_addr1),
    .REG_address2    (rd_addr2),
    .WBA_pend_hit1   (hit1),
    .WBA_pend_hit2   (hit2),
    .WBA_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, "_en"}, 32'(wr_en), 32'(en));
    check({tag, "_addr"}, 32'(wr_addr), 32'(a));
    check({tag, "_data"}, wr_data, d);
    $display("t=%0t %s: wr_en=%0b addr=%0d data=%0h busy=%0b", $time, tag, wr_en, wr_addr, wr_data, busy);
  endtask

  initial begin
    rst_n = 1'b0;
    s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    #12;
    check_wr("reset", 1'b0, 5'd0, 32'h0);
    check("reset_s0_ready", 32'(s0_ready), 32'd1);
    check("reset_s1_ready", 32'(s1_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hit1", 32'(hit1), 32'd0);
    check("reset_hit2", 32'(hit2), 32'd0);
    rst_n = 1'b1;
    step();

    // Single s0 write: load at E1, drop after E2
    s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'hDEADBEEF;
    step();
    s0_valid = 1'b0;
    check("t1_e0_en", 32'(wr_en), 32'd0);
    check("t1_e0_busy", 32'(busy), 32'd1);
    step();
    check_wr("t1_e1", 1'b1, 5'd3, 32'hDEADBEEF);
    step();
    check_wr("t1_e2", 1'b0, 5'd3, 32'hDEADBEEF);
    check("t1_e2_busy", 32'(busy), 32'd0);

    // Simultaneous push: source 1 first
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h11;
    s1_valid = 1'b1; s1_addr = 5'd6; s1_data = 32'h22;
    step();
    s0_valid = 1'b0; s1_valid = 1'b0;
    step();
    check_wr("t2_e1", 1'b1, 5'd6, 32'h22);
    step();
    check_wr("t2_e2", 1'b1, 5'd5, 32'h11);
    step();
    check_wr("t2_e3", 1'b0, 5'd5, 32'h11);

    // s1 streams 6 entries while s0 fills and starves
    s0_valid = 1'b1; s0_addr = 5'd20; s0_data = 32'h200;
    s1_valid = 1'b1; s1_addr = 5'd10; s1_data = 32'h100;
    step();
    s0_addr = 5'd21; s0_data = 32'h201;
    s1_addr = 5'd11; s1_data = 32'h101;
    step();
    check_wr("t3_e1", 1'b1, 5'd10, 32'h100);
    check("t3_e1_s0_ready", 32'(s0_ready), 32'd0);
    s0_addr = 5'd22; s0_data = 32'h202;
    for (int i = 2; i < 6; i++) begin
      s1_addr = AW'(10 + i); s1_data = 32'h100 + 32'(i);
      step();
      check_wr($sformatf("t3_e%0d", i), 1'b1, AW'(9 + i), 32'h100 + 32'(i - 1));
      check($sformatf("t3_e%0d_s0_ready", i), 32'(s0_ready), 32'd0);
    end
    s1_valid = 1'b0;
    step();
    check_wr("t3_e6", 1'b1, 5'd15, 32'h105);
    check("t3_e6_s0_ready", 32'(s0_ready), 32'd0);
    step();
    check_wr("t3_e7", 1'b1, 5'd20, 32'h200);
    check("t3_e7_s0_ready", 32'(s0_ready), 32'd1);
    step();
    s0_valid = 1'b0;
    check_wr("t3_e8", 1'b1, 5'd21, 32'h201);
    step();
    check_wr("t3_e9", 1'b1, 5'd22, 32'h202);
    step();
    check_wr("t3_e10", 1'b0, 5'd22, 32'h202);
    check("t3_e10_busy", 32'(busy), 32'd0);

    // Address 0 is consumed without writing and never hits
    s0_valid = 1'b1; s0_addr = 5'd0; s0_data = 32'hFFFFFFFF;
    step();
    s0_valid = 1'b0;
    check("t4_e0_busy", 32'(busy), 32'd1);
    check("t4_e0_hit1", 32'(hit1), 32'd0);
    step();
    check_wr("t4_e1", 1'b0, 5'd22, 32'h202);
    check("t4_e1_hit1", 32'(hit1), 32'd0);
    check("t4_e1_busy", 32'(busy), 32'd0);

    // Pending hit spans queue residency and the registered write
    rd_addr1 = 5'd7; rd_addr2 = 5'd8;
    #1;
    check("t5_pre_hit1", 32'(hit1), 32'd0);
    s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'hAA;
    step();
    s0_valid = 1'b0;
    check("t5_e0_hit1", 32'(hit1), 32'd1);
    check("t5_e0_hit2", 32'(hit2), 32'd0);
    step();
    check("t5_e1_hit1", 32'(hit1), 32'd1);
    check("t5_e1_hit2", 32'(hit2), 32'd0);
    check_wr("t5_e1", 1'b1, 5'd7, 32'hAA);
    step();
    check("t5_e2_hit1", 32'(hit1), 32'd0);
    rd_addr1 = '0; rd_addr2 = '0;

    // Asynchronous reset with both queues loaded
    s0_valid = 1'b1; s0_addr = 5'd1; s0_data = 32'h1;
    s1_valid = 1'b1; s1_addr = 5'd3; s1_data = 32'h3;
    step();
    s0_addr = 5'd2; s0_data = 32'h2;
    s1_addr = 5'd4; s1_data = 32'h4;
    step();
    s0_valid = 1'b0; s1_valid = 1'b0;
    check_wr("t6_pre", 1'b1, 5'd3, 32'h3);
    check("t6_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_en", 32'(wr_en), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_s0_ready", 32'(s0_ready), 32'd1);
    check("t6_rst_s1_ready", 32'(s1_ready), 32'd1);
    step();
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t6_post%0d_en", i), 32'(wr_en), 32'd0);
      check($sformatf("t6_post%0d_busy", i), 32'(busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
